// File: rtl/intr_ctl.sv
// intr_ctl -- parametrised interrupt controller with programmable timers.
//
// Merges NEXT external request lines, NTIMER down-counting timers and one
// software interrupt into a masked, prioritised CPU interrupt request. Source
// numbering: bits [NEXT-1:0] are the external lines, the next NTIMER bits are
// the timers and the top bit (S = NEXT+NTIMER) is the software interrupt.
// Lowest index wins priority.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-low reset
//   ext_intr   asynchronous external requests (NEXT bits)
//   io_write   single-cycle register write strobe
//   io_addr    register address (5 bits)
//   io_wdata   register write data (16 bits)
//   io_rdata   combinational register read data (16 bits)
//   interrupt  registered: any enabled source pending
//   intr_vec   registered: index of the highest-priority pending source

module intr_ctl #(
   parameter int NEXT   = 2,
   parameter int NTIMER = 2,
   parameter int TW     = 24
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NEXT-1:0] ext_intr,
   input  logic            io_write,
   input  logic [4:0]      io_addr,
   input  logic [15:0]     io_wdata,
   output logic [15:0]     io_rdata,
   output logic            interrupt,
   output logic [3:0]      intr_vec
);

   localparam int S    = NEXT + NTIMER;
   localparam int NSRC = S + 1;
   localparam int HW   = TW - 16;

   // Timer and swi bits are always latched; only these accept set writes.
   localparam logic [NSRC-1:0] LATCH_ONLY = {{(NTIMER + 1){1'b1}}, {NEXT{1'b0}}};

   logic [NEXT-1:0]     sync1;
   logic [NEXT-1:0]     sync2;
   logic [NEXT-1:0]     sync3;
   logic [NEXT-1:0]     edge_mode;
   logic [NSRC-1:0]     enable;
   logic [NSRC-1:0]     latched;
   logic [NSRC-1:0]     latched_next;
   logic [NSRC-1:0]     status;
   logic [NSRC-1:0]     pending;
   logic [NSRC-1:0]     hw_event;
   logic [NSRC-1:0]     wr_set;
   logic [NSRC-1:0]     wr_clr;
   logic [2*NTIMER-1:0] tctrl;
   logic [TW-1:0]       count  [NTIMER];
   logic [TW-1:0]       reload [NTIMER];
   logic [NTIMER-1:0]   cnt_lo_wr;
   logic [NTIMER-1:0]   cnt_hi_wr;
   logic [NTIMER-1:0]   rld_lo_wr;
   logic [NTIMER-1:0]   rld_hi_wr;
   logic [NTIMER-1:0]   expire;
   logic [3:0]          prio;
   logic                wr_enable;
   logic                wr_mode;
   logic                wr_set_reg;
   logic                wr_clr_reg;
   logic                wr_ctrl;

   assign wr_enable  = io_write && (io_addr == 5'd2);
   assign wr_mode    = io_write && (io_addr == 5'd3);
   assign wr_set_reg = io_write && (io_addr == 5'd4);
   assign wr_clr_reg = io_write && (io_addr == 5'd5);
   assign wr_ctrl    = io_write && (io_addr == 5'd7);

   // Two-flop synchroniser for the external lines, plus a third flop holding
   // the previous synced value so a 0->1 transition can be spotted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= '0;
         sync2 <= '0;
         sync3 <= '0;
      end else begin
         sync1 <= ext_intr;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   // Per-timer write decode and expiry detection. A count write in the same
   // cycle suppresses expiry so the written value is never overridden.
   always_comb begin
      cnt_lo_wr = '0;
      cnt_hi_wr = '0;
      rld_lo_wr = '0;
      rld_hi_wr = '0;
      expire    = '0;
      for (int t = 0; t < NTIMER; t++) begin
         cnt_lo_wr[t] = io_write && (io_addr == 5'(16 + 4 * t));
         cnt_hi_wr[t] = io_write && (io_addr == 5'(17 + 4 * t));
         rld_lo_wr[t] = io_write && (io_addr == 5'(18 + 4 * t));
         rld_hi_wr[t] = io_write && (io_addr == 5'(19 + 4 * t));
         expire[t]    = tctrl[2 * t] && !cnt_lo_wr[t] && !cnt_hi_wr[t]
                        && (count[t] == '0);
      end
   end

   // Configuration registers. A one-shot expiry returns its timer to fully
   // idle (run and one-shot both drop) unless software rewrites the control
   // register in that same cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         enable    <= '0;
         edge_mode <= '0;
         tctrl     <= '0;
      end else begin
         if (wr_enable) begin
            enable <= io_wdata[NSRC-1:0];
         end
         if (wr_mode) begin
            edge_mode <= io_wdata[NEXT-1:0];
         end
         if (wr_ctrl) begin
            tctrl <= io_wdata[2*NTIMER-1:0];
         end else begin
            for (int t = 0; t < NTIMER; t++) begin
               if (expire[t] && tctrl[2 * t + 1]) begin
                  tctrl[2 * t]     <= 1'b0;
                  tctrl[2 * t + 1] <= 1'b0;
               end
            end
         end
      end
   end

   // Timer counters. Counting stops at zero; periodic timers reload on the
   // expiry cycle, one-shot timers simply sit at zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int t = 0; t < NTIMER; t++) begin
            count[t]  <= '0;
            reload[t] <= '0;
         end
      end else begin
         for (int t = 0; t < NTIMER; t++) begin
            if (rld_lo_wr[t]) begin
               reload[t][15:0] <= io_wdata;
            end
            if (rld_hi_wr[t]) begin
               reload[t][TW-1:16] <= io_wdata[HW-1:0];
            end
            if (cnt_lo_wr[t]) begin
               count[t][15:0] <= io_wdata;
            end else if (cnt_hi_wr[t]) begin
               count[t][TW-1:16] <= io_wdata[HW-1:0];
            end else if (tctrl[2 * t]) begin
               if (count[t] != '0) begin
                  count[t] <= count[t] - TW'(1);
               end else if (!tctrl[2 * t + 1]) begin
                  count[t] <= reload[t];
               end
            end
         end
      end
   end

   // Latched status bits. Hardware events are OR-ed in after the clear so a
   // clear write can never swallow an event arriving in the same cycle.
   // External bits in level mode are held at zero and ignore writes.
   always_comb begin
      hw_event                = '0;
      hw_event[NEXT-1:0]      = edge_mode & sync2 & ~sync3;
      hw_event[S-1:NEXT]      = expire;
      wr_set                  = wr_set_reg ? (io_wdata[NSRC-1:0] & LATCH_ONLY) : '0;
      wr_clr                  = wr_clr_reg ?
                                (io_wdata[NSRC-1:0] & {{(NTIMER + 1){1'b1}}, edge_mode}) : '0;
      latched_next            = ((latched | wr_set) & ~wr_clr) | hw_event;
      latched_next[NEXT-1:0]  = latched_next[NEXT-1:0] & edge_mode;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         latched <= '0;
      end else begin
         latched <= latched_next;
      end
   end

   // Visible status: level-mode external bits follow the synced input.
   always_comb begin
      status           = latched;
      status[NEXT-1:0] = (edge_mode & latched[NEXT-1:0]) | (~edge_mode & sync2);
      pending          = status & enable;
   end

   // Priority encoder: scanning from the top down leaves the lowest pending
   // index in prio; zero when nothing is pending.
   always_comb begin
      prio = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (pending[i]) begin
            prio = 4'(i);
         end
      end
   end

   // Registered request outputs towards the CPU.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         interrupt <= 1'b0;
         intr_vec  <= '0;
      end else begin
         interrupt <= |pending;
         intr_vec  <= prio;
      end
   end

   // Read mux; unused addresses and unused bits read as zero.
   always_comb begin
      io_rdata = '0;
      case (io_addr)
         5'd0:    io_rdata = 16'(pending);
         5'd1:    io_rdata = 16'(status);
         5'd2:    io_rdata = 16'(enable);
         5'd3:    io_rdata = 16'(edge_mode);
         5'd6:    io_rdata = {interrupt, 11'b0, intr_vec};
         5'd7:    io_rdata = 16'(tctrl);
         default: io_rdata = '0;
      endcase
      for (int t = 0; t < NTIMER; t++) begin
         if (io_addr[4] && (io_addr[3:2] == 2'(t))) begin
            case (io_addr[1:0])
               2'd0:    io_rdata = count[t][15:0];
               2'd1:    io_rdata = 16'(count[t][TW-1:16]);
               2'd2:    io_rdata = reload[t][15:0];
               default: io_rdata = 16'(reload[t][TW-1:16]);
            endcase
         end
      end
   end

endmodule

// File: tb/tb_intr_ctl.sv
// tb_intr_ctl -- self-checking bench for intr_ctl (NEXT=2, NTIMER=2, TW=32).
//
// Directed steps cover reset, priority, edge capture, periodic and one-shot
// timers and full-width counters; randomized rounds compare pending,
// interrupt and intr_vec against expectations built from the source rules.

module tb_intr_ctl;

   localparam int NEXT   = 2;
   localparam int NTIMER = 2;
   localparam int TW     = 32;
   localparam int S      = NEXT + NTIMER;

   logic            clk;
   logic            reset;
   logic [NEXT-1:0] ext_intr;
   logic            io_write;
   logic [4:0]      io_addr;
   logic [15:0]     io_wdata;
   logic [15:0]     io_rdata;
   logic            interrupt;
   logic [3:0]      intr_vec;

   int n_checks = 0;
   int n_fails  = 0;

   intr_ctl #(
      .NEXT   (NEXT),
      .NTIMER (NTIMER),
      .TW     (TW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .ext_intr  (ext_intr),
      .io_write  (io_write),
      .io_addr   (io_addr),
      .io_wdata  (io_wdata),
      .io_rdata  (io_rdata),
      .interrupt (interrupt),
      .intr_vec  (intr_vec)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run always ends.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_fails++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // One register write; the write lands on the posedge inside this task.
   task automatic applyStimulus(input logic [4:0] addr, input logic [15:0] data);
      io_write = 1'b1;
      io_addr  = addr;
      io_wdata = data;
      @(negedge clk);
      io_write = 1'b0;
      io_wdata = '0;
   endtask

   task automatic readReg(input logic [4:0] addr, output logic [15:0] data);
      io_addr = addr;
      #1;
      data = io_rdata;
   endtask

   // Number of clocks until status bit b reads 1, or -1 if it never does.
   task automatic waitStatusBit(input int b, input int bound, output int k);
      logic [15:0] st;
      k = -1;
      for (int i = 1; i <= bound; i++) begin
         @(negedge clk);
         readReg(5'd1, st);
         if (st[b]) begin
            k = i;
            break;
         end
      end
   endtask

   // Reference priority: lowest set index, 0 when none.
   function automatic logic [3:0] lowestSet(input logic [15:0] v);
      for (int i = 0; i < 16; i++) begin
         if (v[i]) return 4'(i);
      end
      return 4'd0;
   endfunction

   initial begin
      logic [15:0] rd;
      logic [15:0] exp_status;
      logic [15:0] exp_pend;
      logic [4:0]  reg_list [14];
      int          k;
      int          c;
      int          r;
      int          e;
      int          en;
      int          sw;

      reg_list = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd6, 5'd7, 5'd16, 5'd17,
                   5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23};

      reset    = 1'b0;
      ext_intr = '0;
      io_write = 1'b0;
      io_addr  = '0;
      io_wdata = '0;

      // Reset state
      repeat (2) @(negedge clk);
      checkOutput("reset_interrupt", 32'(interrupt), 0);
      checkOutput("reset_vec", 32'(intr_vec), 0);
      for (int i = 0; i < 14; i++) begin
         readReg(reg_list[i], rd);
         checkOutput($sformatf("reset_reg%0d", reg_list[i]), 32'(rd), 0);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Reset asserted mid-run
      applyStimulus(5'd2, 16'h001F);
      ext_intr = 2'b01;
      applyStimulus(5'd16, 16'd100);
      applyStimulus(5'd17, 16'd0);
      applyStimulus(5'd7, 16'h0001);
      repeat (4) @(negedge clk);
      checkOutput("prereset_interrupt", 32'(interrupt), 1);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("midreset_interrupt", 32'(interrupt), 0);
      checkOutput("midreset_vec", 32'(intr_vec), 0);
      for (int i = 0; i < 14; i++) begin
         readReg(reg_list[i], rd);
         checkOutput($sformatf("midreset_reg%0d", reg_list[i]), 32'(rd), 0);
      end
      @(negedge clk);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      readReg(5'd0, rd);
      checkOutput("postreset_pending", 32'(rd), 0);
      readReg(5'd1, rd);
      checkOutput("postreset_status", 32'(rd), 32'h1);
      checkOutput("postreset_interrupt", 32'(interrupt), 0);
      ext_intr = 2'b00;
      repeat (3) @(negedge clk);

      // Priority between level external line and swi
      applyStimulus(5'd2, 16'hFFFF);
      applyStimulus(5'd3, 16'h0000);
      ext_intr = 2'b10;
      repeat (4) @(negedge clk);
      checkOutput("prio_ext1_vec", 32'(intr_vec), 1);
      checkOutput("prio_ext1_int", 32'(interrupt), 1);
      applyStimulus(5'd4, 16'h0010);
      repeat (2) @(negedge clk);
      readReg(5'd6, rd);
      checkOutput("prio_both_reg6", 32'(rd), 32'h8001);
      ext_intr = 2'b00;
      repeat (4) @(negedge clk);
      checkOutput("prio_swi_vec", 32'(intr_vec), S);
      readReg(5'd0, rd);
      checkOutput("prio_swi_pending", 32'(rd), 32'h10);
      applyStimulus(5'd4, 16'h0003);
      readReg(5'd1, rd);
      checkOutput("level_ignores_set", 32'(rd), 32'h10);
      applyStimulus(5'd5, 16'h0010);
      repeat (2) @(negedge clk);
      checkOutput("swi_clear_int", 32'(interrupt), 0);
      checkOutput("swi_clear_vec", 32'(intr_vec), 0);
      ext_intr = 2'b01;
      repeat (3) @(negedge clk);
      applyStimulus(5'd5, 16'h0001);
      readReg(5'd1, rd);
      checkOutput("level_ignores_clear", 32'(rd), 32'h1);
      ext_intr = 2'b00;
      repeat (3) @(negedge clk);

      // Edge mode capture
      applyStimulus(5'd3, 16'h0001);
      ext_intr = 2'b01;
      k = -1;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         ext_intr = 2'b00;
         readReg(5'd1, rd);
         if (rd[0] && k < 0) k = i;
      end
      checkOutput("edge_latency", k, 3);
      readReg(5'd1, rd);
      checkOutput("edge_sticky", 32'(rd), 32'h1);
      applyStimulus(5'd5, 16'h0001);
      readReg(5'd1, rd);
      checkOutput("edge_clear", 32'(rd), 0);
      ext_intr = 2'b01;
      @(negedge clk);
      ext_intr = 2'b00;
      @(negedge clk);
      applyStimulus(5'd5, 16'h0001);
      readReg(5'd1, rd);
      checkOutput("edge_vs_clear", 32'(rd), 32'h1);
      applyStimulus(5'd5, 16'h0001);
      applyStimulus(5'd3, 16'h0000);

      // Periodic timer 0: first round fixed, later rounds random
      for (int it = 0; it < 3; it++) begin
         c = (it == 0) ? 5 : int'($urandom_range(0, 9));
         r = (it == 0) ? 5 : int'($urandom_range(1, 9));
         applyStimulus(5'd18, 16'(r));
         applyStimulus(5'd19, 16'd0);
         applyStimulus(5'd16, 16'(c));
         applyStimulus(5'd17, 16'd0);
         applyStimulus(5'd7, 16'h0001);
         waitStatusBit(2, 20, k);
         checkOutput($sformatf("periodic_first_c%0d", c), k, c + 1);
         applyStimulus(5'd5, 16'h0004);
         waitStatusBit(2, 20, k);
         checkOutput($sformatf("periodic_again_r%0d", r), (k < 0) ? k : k + 1, r + 1);
         applyStimulus(5'd7, 16'h0000);
         applyStimulus(5'd5, 16'h0004);
      end

      // One-shot timer 1
      for (int it = 0; it < 2; it++) begin
         c = (it == 0) ? 3 : int'($urandom_range(1, 9));
         applyStimulus(5'd20, 16'(c));
         applyStimulus(5'd21, 16'd0);
         applyStimulus(5'd7, 16'h000C);
         waitStatusBit(3, 20, k);
         checkOutput($sformatf("oneshot_fire_c%0d", c), k, c + 1);
         readReg(5'd7, rd);
         checkOutput("oneshot_ctrl", 32'(rd), 0);
         readReg(5'd20, rd);
         checkOutput("oneshot_count_lo", 32'(rd), 0);
         readReg(5'd21, rd);
         checkOutput("oneshot_count_hi", 32'(rd), 0);
         applyStimulus(5'd5, 16'h0008);
         repeat (10) @(negedge clk);
         readReg(5'd1, rd);
         checkOutput("oneshot_no_repeat", 32'(rd), 0);
      end

      // Full-width counter
      applyStimulus(5'd17, 16'hFFFF);
      applyStimulus(5'd16, 16'hFFFF);
      readReg(5'd16, rd);
      checkOutput("width_lo_rb", 32'(rd), 32'hFFFF);
      readReg(5'd17, rd);
      checkOutput("width_hi_rb", 32'(rd), 32'hFFFF);
      applyStimulus(5'd7, 16'h0001);
      @(negedge clk);
      readReg(5'd16, rd);
      checkOutput("width_dec_lo", 32'(rd), 32'hFFFE);
      readReg(5'd17, rd);
      checkOutput("width_dec_hi", 32'(rd), 32'hFFFF);
      applyStimulus(5'd7, 16'h0000);

      // Randomized level/swi/enable rounds
      applyStimulus(5'd3, 16'h0000);
      for (int it = 0; it < 16; it++) begin
         e  = int'($urandom_range(0, 3));
         en = int'($urandom_range(0, 31));
         sw = int'($urandom_range(0, 1));
         ext_intr = 2'(e);
         applyStimulus(5'd2, 16'(en));
         if (sw != 0) applyStimulus(5'd4, 16'h0010);
         else         applyStimulus(5'd5, 16'h0010);
         repeat (4) @(negedge clk);
         exp_status = (16'(sw) << S) | 16'(e);
         exp_pend   = exp_status & 16'(en);
         readReg(5'd0, rd);
         checkOutput($sformatf("rand%0d_pending", it), 32'(rd), 32'(exp_pend));
         checkOutput($sformatf("rand%0d_int", it), 32'(interrupt), 32'(exp_pend != 0));
         checkOutput($sformatf("rand%0d_vec", it), 32'(intr_vec), 32'(lowestSet(exp_pend)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/intr_ctl.md
Name: intr_ctl

Overview:
- Parametrised interrupt controller and timer block; successor to the fixed 5-source unit.
- Combines NEXT external request lines, NTIMER programmable down-counters and one software interrupt into a masked, prioritised interrupt request with a vector number.
- Sits on the 16-bit io bus next to the uart and sd blocks and drives the CPU interrupt input.

Parameters:
- NEXT, 2: number of external request inputs, 1..8.
- NTIMER, 2: number of timers, 1..4.
- TW, 24: timer counter width, 17..32.
- Constraint: NEXT+NTIMER+1 <= 16.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- ext_intr  in  NEXT  asynchronous external requests.
- io_write  in  1  write strobe, single cycle.
- io_addr  in  5  register address.
- io_wdata  in  16  write data.
- io_rdata  out  16  combinational read data.
- interrupt  out  1  registered: any enabled source pending.
- intr_vec  out  4  registered: index of highest-priority pending source.

Behaviour:
- Source numbering: bits [NEXT-1:0] are ext_intr, next NTIMER bits are timers, the top bit (S=NEXT+NTIMER) is swi.
- Lowest index has the highest priority.
- Unused bits of every register read 0; unused writes are ignored.
- ext_intr passes through a 2-flop synchroniser; sync flops reset to 0.
- Level-mode sources: status = synced input.
- Edge-mode sources: a latched bit is set on a synced 0->1 transition.
  - Input rising to first possible status change takes 3 clk.
- Timer and swi status bits are always latched.
- pending = status & enable.
- interrupt = |pending and intr_vec = priority index are both registered, 1-cycle latency.
- When nothing is pending, intr_vec = 0.
- Register map:
  - 0: pending (R).
  - 1: status (R).
  - 2: enable (RW).
  - 3: edge mode for ext bits (RW, 1 = edge).
  - 4: write-1-set latched bits, swi and timers only.
  - 5: write-1-clear latched bits.
  - 6: {interrupt, 11'b0, intr_vec} (R).
  - 7: timer control (RW): bit 2t = run, bit 2t+1 = one-shot.
  - 16+4t / 17+4t: count lo / hi (RW).
  - 18+4t / 19+4t: reload lo / hi (RW).
  - Hi halves carry TW-16 bits.
- Same-cycle conflicts: a hardware event (edge or timer expiry) in the same cycle as a clear write leaves the bit set, so events are never lost.
- Level-mode bits ignore set and clear writes.
- Timer t, each clk:
  - If a count write is present, the write wins: the half is written and no expiry occurs that cycle.
  - Else if run=0: hold.
  - Else if count != 0: decrement.
  - Else (count == 0): set latched bit t.
    - Periodic: count <= reload.
    - One-shot: count holds at 0 and run bit auto-clears.
- Reload=0 in periodic mode raises an expiry every cycle.
- The counter never wraps below 0.
- Reset values: all registers 0, timers stopped, interrupt=0, intr_vec=0, io_rdata reflects the zeroed registers.
- Assertion of reset mid-count clears immediately and asynchronously.

Test Plan:
- Reset: enable=0x001F, ext_intr[0] held high, then reset asserted mid-run -> interrupt=0 and all registers read 0 immediately; after deassert with enable=0, pending reads 0.
- Priority: enable=0xFFFF, level mode, ext_intr=2'b10, then swi set via addr 4 -> intr_vec=1; drop ext_intr[1] -> intr_vec=S=4 (NEXT=2, NTIMER=2).
- Edge mode: mode=0x1, 1-cycle pulse on ext_intr[0] -> status[0] set 3 clk later and stays set; write 0x1 to addr 5 -> cleared; pulse coinciding with the clear -> stays set.
- Periodic timer 0: reload=5, count=5, run=1 -> status[2] set after 6 clk; after clear, set again 6 clk later.
- One-shot timer 1: count=3, control=0xC -> status[3] set once, control reads 0x0, count stays 0, no further events.
- Width: TW=32, write count hi=0xFFFF and lo=0xFFFF -> reads back 0xFFFF/0xFFFF and decrements to 0xFFFE lo after 1 clk of run.
